// File: rtl/clk_div_ctrl.sv
// Arbitrated, glitch-safe ratio reconfiguration controller for a ClkDiv instance.
// Define CLK_DIV_CTRL_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module clk_div_ctrl #(
   parameter int unsigned RATIO_WIDTH   = 4,
   parameter int unsigned GUARD_CYCLES  = 2,
   parameter int unsigned DEFAULT_RATIO = 2
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst,
   input  logic                   i_run,
   input  logic [1:0]             i_req,
   input  logic [RATIO_WIDTH-1:0] i_ratio0,
   input  logic [RATIO_WIDTH-1:0] i_ratio1,
   output logic [1:0]             o_ack,
   output logic [1:0]             o_err,
   output logic                   o_busy,
   output logic                   o_clk_en,
   output logic [RATIO_WIDTH-1:0] o_div_ratio
);

   localparam int unsigned GUARD_W = 4;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] DRAIN  = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] SETTLE = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] ERR    = 3'd5;

   logic [2:0]             state_q, state_d;
   logic                   grant_q, grant_d;
   logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
   logic [GUARD_W-1:0]     guard_cnt_q, guard_cnt_d;
   logic [RATIO_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
   logic                   clk_en_q, clk_en_d;
   logic [RATIO_WIDTH-1:0] div_ratio_q, div_ratio_d;
   logic [1:0]             ack_q, ack_d;
   logic [1:0]             err_q, err_d;
   logic                   sel_c;
   logic [RATIO_WIDTH-1:0] sel_ratio_c;

   // Requester selection for the current IDLE cycle
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;
   assign sel_c = (&i_req) ? ptr_q : i_req[1];
`else
   assign sel_c = ~i_req[0];
`endif
   assign sel_ratio_c = sel_c ? i_ratio1 : i_ratio0;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ratio_d      = ratio_q;
      guard_cnt_d  = guard_cnt_q;
      settle_cnt_d = settle_cnt_q;
      clk_en_d     = clk_en_q;
      div_ratio_d  = div_ratio_q;
      ack_d        = 2'b00;
      err_d        = 2'b00;
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            clk_en_d = i_run;
            if (|i_req) begin
               grant_d = sel_c;
               ratio_d = sel_ratio_c;
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
               ptr_d   = ~sel_c;
`endif
               if (sel_ratio_c < RATIO_WIDTH'(2)) begin
                  // Rejected ratio leaves the divider untouched
                  state_d       = ERR;
                  clk_en_d      = clk_en_q;
                  err_d[sel_c]  = 1'b1;
               end else if (sel_ratio_c == div_ratio_q) begin
                  state_d       = DONE;
                  ack_d[sel_c]  = 1'b1;
               end else begin
                  state_d     = DRAIN;
                  clk_en_d    = 1'b0;
                  guard_cnt_d = GUARD_W'(1);
               end
            end
         end
         DRAIN: begin
            clk_en_d = 1'b0;
            if (guard_cnt_q == GUARD_W'(GUARD_CYCLES)) begin
               state_d = LOAD;
            end else begin
               guard_cnt_d = guard_cnt_q + GUARD_W'(1);
            end
         end
         LOAD: begin
            // Ratio lands while the enable is still low; enable returns with it
            div_ratio_d  = ratio_q;
            clk_en_d     = i_run;
            settle_cnt_d = RATIO_WIDTH'(1);
            state_d      = SETTLE;
         end
         SETTLE: begin
            clk_en_d = i_run;
            if (settle_cnt_q == div_ratio_q) begin
               state_d         = DONE;
               ack_d[grant_q]  = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q + RATIO_WIDTH'(1);
            end
         end
         DONE: begin
            clk_en_d = i_run;
            state_d  = IDLE;
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         ratio_q      <= '0;
         guard_cnt_q  <= '0;
         settle_cnt_q <= '0;
         clk_en_q     <= 1'b0;
         div_ratio_q  <= RATIO_WIDTH'(DEFAULT_RATIO);
         ack_q        <= 2'b00;
         err_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         ratio_q      <= ratio_d;
         guard_cnt_q  <= guard_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         clk_en_q     <= clk_en_d;
         div_ratio_q  <= div_ratio_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
      end
   end

`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign o_ack       = ack_q;
   assign o_err       = err_q;
   assign o_busy      = (state_q != IDLE);
   assign o_clk_en    = clk_en_q;
   assign o_div_ratio = div_ratio_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: per-cycle timing checks plus a response scoreboard.
module tb_clk_div_ctrl;

   localparam int unsigned RW = 4;
   localparam int unsigned G  = 2;

   typedef struct packed {
      logic [1:0] ack;
      logic [1:0] err;
   } resp_t;

   logic          clk;
   logic          rst;
   logic          run;
   logic [1:0]    req;
   logic [RW-1:0] ratio0;
   logic [RW-1:0] ratio1;
   logic [1:0]    ack;
   logic [1:0]    err;
   logic          busy;
   logic          clk_en;
   logic [RW-1:0] div_ratio;

   int            checks;
   int            errors;
   resp_t         sb[$];
   logic [RW-1:0] cur_ratio;
   int            first;
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
   int            exp_ptr;
`endif

   clk_div_ctrl #(
      .RATIO_WIDTH   (RW),
      .GUARD_CYCLES  (G),
      .DEFAULT_RATIO (2)
   ) dut (
      .i_ref_clk   (clk),
      .i_rst       (rst),
      .i_run       (run),
      .i_req       (req),
      .i_ratio0    (ratio0),
      .i_ratio1    (ratio1),
      .o_ack       (ack),
      .o_err       (err),
      .o_busy      (busy),
      .o_clk_en    (clk_en),
      .o_div_ratio (div_ratio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one request and follow it cycle by cycle until the IDLE cycle after its response
   task automatic serve(input int rq, input logic [RW-1:0] r);
      int         n;
      logic [1:0] bitv;
      logic [RW-1:0] old;
      bit         chg;
      resp_t      e;
      resp_t      got;
      bitv = (rq == 0) ? 2'b01 : 2'b10;
      req[rq] = 1'b1;
      if (rq == 0) ratio0 = r; else ratio1 = r;
      old = cur_ratio;
      if (int'(r) < 2) begin
         e.ack = 2'b00; e.err = bitv; n = 1; chg = 1'b0;
      end else if (r == old) begin
         e.ack = bitv; e.err = 2'b00; n = 1; chg = 1'b0;
      end else begin
         e.ack = bitv; e.err = 2'b00; n = int'(G) + int'(r) + 2; chg = 1'b1;
      end
      sb.push_back(e);
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
      exp_ptr = (rq == 0) ? 1 : 0;
`endif
      for (int i = 1; i <= n; i++) begin
         step();
         if (i == 1) begin
            if (rq == 0) ratio0 = ~r; else ratio1 = ~r;
         end
         check("busy", 32'(busy), 32'd1);
         check("clk_en", 32'(clk_en), (chg && i <= int'(G) + 1) ? 32'd0 : 32'd1);
         check("div_ratio", 32'(div_ratio), (chg && i >= int'(G) + 2) ? 32'(r) : 32'(old));
         check("ack_timing", 32'(ack), (i == n) ? 32'(e.ack) : 32'd0);
         check("err_timing", 32'(err), (i == n) ? 32'(e.err) : 32'd0);
         if ((ack | err) != 2'b00) begin
            if (sb.size() == 0) begin
               check("sb_unexpected", 32'(ack | err), 32'd0);
            end else begin
               got = sb.pop_front();
               check("sb_ack", 32'(ack), 32'(got.ack));
               check("sb_err", 32'(err), 32'(got.err));
            end
         end
      end
      req[rq] = 1'b0;
      if (chg) cur_ratio = r;
      step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ack", 32'(ack | err), 32'd0);
      check("idle_ratio", 32'(div_ratio), 32'(cur_ratio));
      check("idle_clk_en", 32'(clk_en), 32'd1);
   endtask

   task automatic both_round(input logic [RW-1:0] r0, input logic [RW-1:0] r1);
      req    = 2'b11;
      ratio0 = r0;
      ratio1 = r1;
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
      first = exp_ptr;
`else
      first = 0;
`endif
      if (first == 0) begin
         serve(0, r0);
         serve(1, r1);
      end else begin
         serve(1, r1);
         serve(0, r0);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cur_ratio = 4'd2;
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
      exp_ptr   = 0;
`endif
      rst    = 1'b1;
      run    = 1'b0;
      req    = 2'b00;
      ratio0 = '0;
      ratio1 = '0;
      step();
      step();
      check("rst_clk_en", 32'(clk_en), 32'd0);
      check("rst_ratio", 32'(div_ratio), 32'd2);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      rst = 1'b0;
      run = 1'b1;
      #1;
      check("run_latency", 32'(clk_en), 32'd0);
      step();
      check("run_clk_en", 32'(clk_en), 32'd1);
      check("run_ratio", 32'(div_ratio), 32'd2);
      check("run_busy", 32'(busy), 32'd0);

      serve(0, 4'd2);
      serve(0, 4'd4);
      serve(1, 4'd15);
      serve(1, 4'd1);
      serve(0, 4'd0);
      both_round(4'd3, 4'd5);
      both_round(4'd6, 4'd7);

      // Reset in the middle of SETTLE, request kept high throughout
      req    = 2'b01;
      ratio0 = 4'd9;
      for (int i = 0; i < int'(G) + 4; i++) step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_clk_en", 32'(clk_en), 32'd0);
      check("mid_rst_ratio", 32'(div_ratio), 32'd2);
      check("mid_rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("mid_rst_ack", 32'(ack | err), 32'd0);
      end
      cur_ratio = 4'd2;
`ifdef CLK_DIV_CTRL_ROUND_ROBIN_EN
      exp_ptr = 0;
`endif
      rst = 1'b0;
      serve(0, 4'd9);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
